// File: rtl/rx_buffer_pkg.sv
// Shared types and constants for the UART receive path.
// Entries pack the parity error bit above the received byte.
package uart_rx_pkg;

  localparam int DATA_W        = 8;
  localparam int ENTRY_W       = 9;
  localparam int ERR_BIT       = 8;
  localparam int RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

  function automatic rx_entry_t makeEntry(input logic err, input logic [DATA_W-1:0] data);
    logic [ENTRY_W-1:0] raw;
    raw              = {ENTRY_W{1'b0}};
    raw[ERR_BIT]     = err;
    raw[DATA_W-1:0]  = data;
    return rx_entry_t'(raw);
  endfunction

endpackage

// File: rtl/rx_buffer_if.sv
// Receiver-facing and host-facing signals of the receive buffer.
// The slave modport is the buffer; the master modport is its environment.
interface rx_buffer_if
  import uart_rx_pkg::*;
#(
  parameter int ADDR_W = 4
);

  logic              DoneFlag;
  logic              ErrorFlag;
  logic [DATA_W-1:0] Data;
  logic              RdEn;
  logic              OvfClr;
  logic [DATA_W-1:0] RdData;
  logic              RdErr;
  logic              RdValid;
  logic              Empty;
  logic              Full;
  logic [ADDR_W:0]   Count;
  logic              Overflow;

  modport master (
    output DoneFlag, ErrorFlag, Data, RdEn, OvfClr,
    input  RdData, RdErr, RdValid, Empty, Full, Count, Overflow
  );

  modport slave (
    input  DoneFlag, ErrorFlag, Data, RdEn, OvfClr,
    output RdData, RdErr, RdValid, Empty, Full, Count, Overflow
  );

endinterface

// File: rtl/rx_buffer_sync.sv
// Two-flop synchronizer with a single-cycle pulse on each rising edge
// of an asynchronous level flag.
module sync_rise_detect (
  input  logic Clock,
  input  logic ResetN,
  input  logic AsyncIn,
  output logic Pulse
);

  logic       sync0_r;
  logic       sync1_r;
  logic       prev_r;
  logic [1:0] fill_r;
  logic       armed_r;

  // Synchronizer chain; after reset, edges are only reported once a genuine
  // low has been seen, so a flag held high across reset is not a new edge.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      sync0_r <= 1'b0;
      sync1_r <= 1'b0;
      prev_r  <= 1'b0;
      fill_r  <= 2'b00;
      armed_r <= 1'b0;
    end else begin
      sync0_r <= AsyncIn;
      sync1_r <= sync0_r;
      prev_r  <= sync1_r;
      fill_r  <= {fill_r[0], 1'b1};
      armed_r <= armed_r | (fill_r[1] & ~sync1_r);
    end
  end

  assign Pulse = sync1_r & ~prev_r & armed_r;

endmodule

// File: rtl/rx_buffer.sv
// Circular FIFO of {error, data} frames from the UART receiver, read by
// the host with a one-entry-per-cycle enable and registered read data.
module rx_buffer
  import uart_rx_pkg::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic         Clock,
  input logic         ResetN,
  rx_buffer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);

  rx_entry_t         mem_r [DEPTH];
  logic [ADDR_W-1:0] wrPtr_r;
  logic [ADDR_W-1:0] rdPtr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   countNext_s;
  logic              empty_r;
  logic              full_r;
  logic              overflow_r;
  logic              rdValid_r;
  logic              rdErr_r;
  logic [DATA_W-1:0] rdData_r;

  logic wrReq_s;
  logic rdAcc_s;
  logic wrAcc_s;
  logic drop_s;

  sync_rise_detect uDoneSync (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .AsyncIn (bus.DoneFlag),
    .Pulse   (wrReq_s)
  );

  // Accept/drop decisions; a read in the same cycle frees the slot a full FIFO needs.
  always_comb begin
    rdAcc_s     = 1'b0;
    wrAcc_s     = 1'b0;
    drop_s      = 1'b0;
    countNext_s = count_r;
    rdAcc_s     = bus.RdEn & ~empty_r;
    wrAcc_s     = wrReq_s & (~full_r | rdAcc_s);
    drop_s      = wrReq_s & full_r & ~rdAcc_s;
    case ({wrAcc_s, rdAcc_s})
      2'b10:   countNext_s = count_r + CNT_ONE;
      2'b01:   countNext_s = count_r - CNT_ONE;
      default: countNext_s = count_r;
    endcase
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      wrPtr_r    <= {ADDR_W{1'b0}};
      rdPtr_r    <= {ADDR_W{1'b0}};
      count_r    <= CNT_ZERO;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wrAcc_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (rdAcc_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      count_r <= countNext_s;
      empty_r <= (countNext_s == CNT_ZERO);
      full_r  <= (countNext_s == CNT_DEPTH);
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (bus.OvfClr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Entry storage; deliberately not cleared by reset.
  always_ff @(posedge Clock) begin
    if (ResetN && wrAcc_s) begin
      mem_r[wrPtr_r] <= makeEntry(bus.ErrorFlag, bus.Data);
    end
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      rdData_r  <= {DATA_W{1'b0}};
      rdErr_r   <= 1'b0;
      rdValid_r <= 1'b0;
    end else begin
      rdValid_r <= rdAcc_s;
      if (rdAcc_s) begin
        rdData_r <= mem_r[rdPtr_r].data;
        rdErr_r  <= mem_r[rdPtr_r].err;
      end
    end
  end

  assign bus.RdData   = rdData_r;
  assign bus.RdErr    = rdErr_r;
  assign bus.RdValid  = rdValid_r;
  assign bus.Empty    = empty_r;
  assign bus.Full     = full_r;
  assign bus.Count    = count_r;
  assign bus.Overflow = overflow_r;

endmodule

// File: tb/tb_rx_buffer.sv
// Randomized scoreboard bench for rx_buffer: a queue-based FIFO model
// predicts read results, and a monitor checks every RdValid pulse.
module tb_rx_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  typedef struct {
    logic [7:0] d;
    logic       e;
  } ent_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  rx_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  rx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clock  (clk),
    .ResetN (rstN),
    .bus    (bus)
  );

  ent_t model[$];
  ent_t expQ[$];
  logic ovfExp = 1'b0;
  int   nChecks = 0;
  int   nPass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Frame arrives from the receiver; write must land within three cycles.
  task automatic sendFrame(input logic [7:0] d, input logic e);
    ent_t x;
    x.d = d;
    x.e = e;
    if (model.size() < DEPTH) model.push_back(x);
    else ovfExp = 1'b1;
    bus.Data      = d;
    bus.ErrorFlag = e;
    bus.DoneFlag  = 1'b1;
    repeat (3) tick();
    chk("count_after_write", int'(bus.Count), model.size());
    chk("overflow_after_write", int'(bus.Overflow), int'(ovfExp));
    repeat (2) tick();
    bus.DoneFlag = 1'b0;
    repeat (4) tick();
  endtask

  task automatic readOne();
    int had;
    had = (model.size() > 0) ? 1 : 0;
    if (had != 0) expQ.push_back(model.pop_front());
    bus.RdEn = 1'b1;
    tick();
    bus.RdEn = 1'b0;
    chk("rdvalid_pulse", int'(bus.RdValid), had);
    chk("count_after_read", int'(bus.Count), model.size());
    chk("empty_after_read", int'(bus.Empty), (model.size() == 0) ? 1 : 0);
  endtask

  task automatic clrOvf();
    bus.OvfClr = 1'b1;
    tick();
    bus.OvfClr = 1'b0;
    ovfExp = 1'b0;
    chk("overflow_cleared", int'(bus.Overflow), 0);
  endtask

  // Write lands at the third edge after DoneFlag rises; read is aligned to it.
  task automatic fullSimul(input logic [7:0] d, input logic e);
    ent_t x;
    x.d = d;
    x.e = e;
    expQ.push_back(model.pop_front());
    model.push_back(x);
    bus.Data      = d;
    bus.ErrorFlag = e;
    bus.DoneFlag  = 1'b1;
    tick();
    tick();
    bus.RdEn = 1'b1;
    chk("simul_count_before", int'(bus.Count), DEPTH);
    tick();
    bus.RdEn = 1'b0;
    chk("simul_count_after", int'(bus.Count), model.size());
    chk("simul_overflow", int'(bus.Overflow), int'(ovfExp));
    chk("simul_full", int'(bus.Full), 1);
    repeat (2) tick();
    bus.DoneFlag = 1'b0;
    repeat (4) tick();
  endtask

  // Monitor: every RdValid pulse must match the oldest predicted read.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.RdValid === 1'b1) begin
        if (expQ.size() == 0) begin
          nChecks++;
          $display("FAIL unexpected_rdvalid: got RdData=%0h with no read outstanding at %0t",
                   bus.RdData, $time);
        end else begin
          e = expQ.pop_front();
          chk("rd_data", int'(bus.RdData), int'(e.d));
          chk("rd_err", int'(bus.RdErr), int'(e.e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed so far", nPass, nChecks);
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    rstN          = 1'b0;
    bus.DoneFlag  = 1'b1;
    bus.ErrorFlag = 1'b0;
    bus.Data      = 8'h00;
    bus.RdEn      = 1'b0;
    bus.OvfClr    = 1'b0;
    repeat (3) tick();
    chk("reset_empty", int'(bus.Empty), 1);
    chk("reset_count", int'(bus.Count), 0);
    chk("reset_overflow", int'(bus.Overflow), 0);
    chk("reset_rdvalid", int'(bus.RdValid), 0);
    chk("reset_full", int'(bus.Full), 0);
    rstN = 1'b1;
    repeat (6) tick();
    chk("no_spurious_write", int'(bus.Count), 0);
    bus.DoneFlag = 1'b0;
    repeat (4) tick();

    // Single frame
    sendFrame(8'hA5, 1'b0);
    chk("single_not_empty", int'(bus.Empty), 0);
    readOne();

    // Error tagging and ordering
    sendFrame(8'h11, 1'b0);
    sendFrame(8'h22, 1'b1);
    sendFrame(8'h33, 1'b0);
    repeat (3) readOne();

    // Full and overflow
    for (int i = 0; i < 17; i++) begin
      sendFrame(8'(i), 1'b0);
      if (i == 15) chk("full_after_16", int'(bus.Full), 1);
    end
    chk("full_count", int'(bus.Count), DEPTH);
    repeat (16) readOne();
    clrOvf();

    // Refill, then simultaneous write and read at full
    for (int i = 0; i < DEPTH; i++) sendFrame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    fullSimul(8'hC3, 1'b1);

    // Mixed random operations to exercise pointer wrap
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1: sendFrame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        2: readOne();
        default: if (ovfExp) clrOvf(); else readOne();
      endcase
    end
    while (model.size() > 0) readOne();
    if (ovfExp) clrOvf();

    // Read while empty is ignored
    readOne();

    // Reset mid-stream
    for (int i = 0; i < 5; i++) sendFrame(8'h40 + 8'(i), 1'(i % 2));
    chk("pre_reset_count", int'(bus.Count), 5);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    model.delete();
    ovfExp = 1'b0;
    chk("midreset_count", int'(bus.Count), 0);
    chk("midreset_empty", int'(bus.Empty), 1);
    repeat (4) tick();
    rd = 8'h5A;
    sendFrame(rd, 1'b1);
    readOne();

    repeat (3) tick();
    chk("scoreboard_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/rx_buffer.md
Name: rx_buffer

Overview:
- Receive-side byte buffer directly downstream of the UART receiver unit.
- Consumes the receiver's Data[7:0], ErrorFlag and DoneFlag outputs.
- Stores each completed frame as a {error, data} entry in a circular FIFO.
- Presents entries to the host through a read-enable handshake, with occupancy status and a sticky overflow flag.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 4, pointer width; equals log2(DEPTH).

Ports:
- Clock  input  1  system main clock; all logic on the rising edge.
- ResetN  input  1  synchronous, active-low reset.
- DoneFlag  input  1  frame-complete level from the receiver; asynchronous to Clock.
- ErrorFlag  input  1  parity error for the frame currently on Data.
- Data  input  8  received byte; stable while DoneFlag is high.
- RdEn  input  1  host read request; one entry popped per cycle when asserted.
- OvfClr  input  1  clears the Overflow flag.
- RdData  output  8  byte of the last popped entry.
- RdErr  output  1  error bit of the last popped entry.
- RdValid  output  1  one-cycle pulse: RdData/RdErr updated this cycle.
- Empty  output  1  high when Count == 0.
- Full  output  1  high when Count == DEPTH.
- Count  output  ADDR_W+1  number of stored entries.
- Overflow  output  1  sticky; a frame was dropped because the FIFO was full.

Behaviour:
- Reset (ResetN low at a rising edge):
  - Pointers = 0, Count = 0, Empty = 1, Full = 0.
  - RdData = 0, RdErr = 0, RdValid = 0, Overflow = 0.
  - Synchronizer flops = 0.
  - Storage contents are not cleared.
  - Reset mid-operation discards all entries and any in-flight capture.
- DoneFlag synchronizer:
  - Two flops sync0 → sync1, plus a previous-value flop prev.
  - wr_req = sync1 & ~prev, a single-cycle pulse per DoneFlag rising edge.
  - Latency from DoneFlag rising to wr_req: 2–3 Clock cycles.
  - Data and ErrorFlag are sampled directly at wr_req. They are guaranteed stable because the receiver holds them for a full frame time.
- Write:
  - On wr_req with Full = 0: mem[wr_ptr] = {ErrorFlag, Data}; wr_ptr += 1, wrapping modulo DEPTH.
  - On wr_req with Full = 1 and no accepted read in the same cycle: the entry is dropped and Overflow is set to 1.
- Read:
  - On RdEn with Empty = 0: {RdErr, RdData} = mem[rd_ptr] at the next edge; RdValid = 1 for that one cycle; rd_ptr += 1, wrapping.
  - RdEn while Empty = 1 is ignored: RdValid = 0, RdData/RdErr hold their values.
  - RdData/RdErr hold their last value between reads.
- Simultaneous events:
  - Read and write in the same cycle, FIFO not empty and not full: both occur, Count unchanged.
  - Full + wr_req + accepted RdEn: both occur, no overflow, Count stays DEPTH.
  - Empty + wr_req + RdEn: only the write occurs; there is no fall-through. Count becomes 1 and RdValid = 0.
- Count:
  - Count += 1 on an accepted write only; Count -= 1 on an accepted read only.
  - Empty and Full are decoded from the registered Count.
- Overflow:
  - OvfClr = 1 clears Overflow.
  - OvfClr together with a new drop in the same cycle: the set wins, Overflow = 1.
- No combinational path from any input to any output.

Decomposition:
- Package uart_rx_pkg holds:
  - DATA_W = 8, ENTRY_W = 9, ERR_BIT = 8.
  - Default RX_FIFO_DEPTH = 16.
  - The {err, data} entry typedef.
- Sub-module sync_rise_detect:
  - 2-flop synchronizer plus rising-edge pulse.
  - Ports Clock, ResetN, AsyncIn, Pulse.
  - Reusable for other asynchronous flags such as the transmitter done signal.

Test Plan:
- Reset: hold ResetN = 0 for 3 cycles with DoneFlag = 1 → Empty = 1, Count = 0, Overflow = 0, RdValid = 0. After release, no spurious write while DoneFlag stays high.
- Single frame: Data = 0xA5, ErrorFlag = 0, raise DoneFlag → within 3 cycles Count = 1 and Empty = 0. Pulse RdEn → next cycle RdValid = 1, RdData = 0xA5, RdErr = 0, Empty = 1.
- Error tagging and ordering: write 0x11 (err 0), 0x22 (err 1), 0x33 (err 0) → three reads return 0x11/0, 0x22/1, 0x33/0 in order.
- Full and overflow: write 17 frames 0x00..0x10 with no reads → Full = 1 after the 16th, Count = 16, Overflow = 1 after the 17th. Reads return 0x00..0x0F and 0x10 is absent. OvfClr → Overflow = 0.
- Simultaneous at full: with Count = 16, align wr_req with RdEn → Count stays 16, Overflow stays 0, the new byte is read last. Pointers wrap correctly over 40 further mixed operations.
- Empty read and reset mid-stream: RdEn with Empty = 1 → no RdValid. With Count = 5, assert ResetN = 0 for 1 cycle → Count = 0, Empty = 1, and the next frame is read correctly from a fresh start.
